// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmit sequencer, the
// receive side and the register block.
//   tx_state_e     : transmit sequencer states
//   WLS_*          : word length select encodings (5..8 data bits)
//   uart_lcr_t     : line control fields {bc, sp, eps, pen, stb, wls}
//   wls_data_mask  : mask that keeps only the data bits a word length sends
//   wls_last_bit   : bit counter value of the last data bit for a word length
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic [1:0] WLS_5 = 2'b00;
   localparam logic [1:0] WLS_6 = 2'b01;
   localparam logic [1:0] WLS_7 = 2'b10;
   localparam logic [1:0] WLS_8 = 2'b11;

   typedef struct packed {
      logic       bc;
      logic       sp;
      logic       eps;
      logic       pen;
      logic       stb;
      logic [1:0] wls;
   } uart_lcr_t;

   function automatic logic [7:0] wls_data_mask(input logic [1:0] sel);
      logic [7:0] mask;
      case (sel)
         WLS_5:   mask = 8'h1F;
         WLS_6:   mask = 8'h3F;
         WLS_7:   mask = 8'h7F;
         WLS_8:   mask = 8'hFF;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

   // The bit counter starts at 0, so the last data bit sits at (wls + 4).
   function automatic logic [2:0] wls_last_bit(input logic [1:0] sel);
      return {1'b0, sel} + 3'd4;
   endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: transmit-holding handshake between the register block
// (master) and the transmit sequencer (slave).
//   tx_data  : byte to transmit
//   tx_valid : tx_data is valid
//   tx_ready : holding register empty; a transfer happens on tx_valid & tx_ready
interface uart_tx_ctrl_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input  tx_ready);
   modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer. Frames bytes from the holding
// register into start/data/parity/stop bits, advancing one bit per
// transmit_edge pulse from the baud generator.
// Ports:
//   pclk, preset      : clock, synchronous active-high reset
//   tx_if (slave)     : tx_data / tx_valid / tx_ready holding-register handshake
//   wls, stb, pen,
//   eps, sp, bc       : line control (latched per frame, except bc which is live)
//   transmit_edge     : one-cycle pulse per bit period
//   transmit_clk_clr  : one-cycle pulse restarting the baud counter on idle->active
//   txd               : serial output, idle high (registered)
//   thre              : holding register empty
//   temt              : holding register empty and sequencer idle
module uart_tx_ctrl
   import uart_pkg::*;
(
   input  logic          pclk,
   input  logic          preset,
   uart_tx_ctrl_if.slave tx_if,
   input  logic [1:0]    wls,
   input  logic          stb,
   input  logic          pen,
   input  logic          eps,
   input  logic          sp,
   input  logic          bc,
   input  logic          transmit_edge,
   output logic          transmit_clk_clr,
   output logic          txd,
   output logic          thre,
   output logic          temt
);

   tx_state_e  state_q, state_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       stop_cnt_q, stop_cnt_d;
   logic [1:0] frame_wls_q, frame_wls_d;
   logic       frame_stb_q, frame_stb_d;
   logic       frame_pen_q, frame_pen_d;
   logic       parity_q, parity_d;
   logic       start_pend_q, start_pend_d;
   logic       txd_q, txd_d;
   logic       clr_q, clr_d;

   uart_lcr_t  lcr;
   logic       bit_edge;
   logic       do_load;
   logic       data_xor;

   assign lcr = '{bc: bc, sp: sp, eps: eps, pen: pen, stb: stb, wls: wls};

   // A bit edge is ignored while the baud counter is being realigned:
   // both in the cycle that schedules the clear and in the clear cycle itself,
   // so START always spans a full bit period.
   assign bit_edge = transmit_edge & ~clr_q & ~start_pend_q;

   // Parity only covers the data bits that the latched word length sends.
   assign data_xor = ^(hold_q & wls_data_mask(lcr.wls));

   // Next-state logic: holding register, sequencer, shifter and the registered
   // txd / transmit_clk_clr values.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      stop_cnt_d   = stop_cnt_q;
      frame_wls_d  = frame_wls_q;
      frame_stb_d  = frame_stb_q;
      frame_pen_d  = frame_pen_q;
      parity_d     = parity_q;
      start_pend_d = 1'b0;
      clr_d        = start_pend_q;
      do_load      = 1'b0;

      if (tx_if.tx_valid && !hold_full_q) begin
         hold_d      = tx_if.tx_data;
         hold_full_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (hold_full_q) begin
               do_load      = 1'b1;
               state_d      = START;
               start_pend_d = 1'b1;
            end
         end
         START: begin
            if (bit_edge) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
            end
         end
         DATA: begin
            if (bit_edge) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_cnt_q == wls_last_bit(frame_wls_q)) begin
                  bit_cnt_d = 3'd0;
                  state_d   = frame_pen_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_edge) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_edge) begin
               if (frame_stb_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  stop_cnt_d = 1'b0;
                  // Chaining straight into START keeps the baud phase, so no clear.
                  if (hold_full_q) begin
                     do_load = 1'b1;
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_load) begin
         shift_d     = hold_q;
         hold_full_d = 1'b0;
         frame_wls_d = lcr.wls;
         frame_stb_d = lcr.stb;
         frame_pen_d = lcr.pen;
         if (lcr.sp) begin
            parity_d = ~lcr.eps;
         end else begin
            parity_d = lcr.eps ? data_xor : ~data_xor;
         end
      end

      if (lcr.bc) begin
         txd_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            PARITY:  txd_d = parity_q;
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
         endcase
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q      <= IDLE;
         hold_q       <= 8'h00;
         hold_full_q  <= 1'b0;
         shift_q      <= 8'h00;
         bit_cnt_q    <= 3'd0;
         stop_cnt_q   <= 1'b0;
         frame_wls_q  <= WLS_8;
         frame_stb_q  <= 1'b0;
         frame_pen_q  <= 1'b0;
         parity_q     <= 1'b0;
         start_pend_q <= 1'b0;
         txd_q        <= 1'b1;
         clr_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
         frame_wls_q  <= frame_wls_d;
         frame_stb_q  <= frame_stb_d;
         frame_pen_q  <= frame_pen_d;
         parity_q     <= parity_d;
         start_pend_q <= start_pend_d;
         txd_q        <= txd_d;
         clr_q        <= clr_d;
      end
   end

   assign tx_if.tx_ready   = ~hold_full_q;
   assign thre             = ~hold_full_q;
   assign temt             = ~hold_full_q && (state_q == IDLE);
   assign txd              = txd_q;
   assign transmit_clk_clr = clr_q;

endmodule
